arena_border_scanner: RTL and testbench

Sequential reader for the arena border RAM: given a packed pixel location, it walks the RAM one address per cycle and reports whether that location is a border pixel and, if so, where it is stored. It sits between game logic (tank/bullet collision checks) and the single read/write port of the border RAM. The block drives the RAM's address and read-enable and consumes its registered one-cycle-latency read data.

---
 rtl/arena_pkg.sv | 17 +
 rtl/arena_border_scanner.sv | 97 +++++++++
 tb/tb_arena_border_scanner.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/arena_pkg.sv
// Shared definitions for the arena border RAM and its scanner.
// Holds the scanner state encoding and the RAM geometry defaults.
package arena_pkg;

  localparam int ARENA_DATA_WIDTH = 32;
  localparam int ARENA_ADDRESS_WIDTH = 10;
  localparam int ARENA_DEPTH = 1024;
  localparam logic [31:0] ARENA_SENTINEL = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } scan_state_t;

endpackage

// File: rtl/arena_border_scanner.sv
// Sequential border-RAM search: walks addresses from 0 looking for query.
// Ports: clk/reset; start/query request; busy/done/hit/hitAddr result;
//        ramAddr/ramReadEn/ramData drive the one-cycle-latency RAM port.
module arena_border_scanner
  import arena_pkg::*;
#(
  parameter int DATA_WIDTH = ARENA_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = ARENA_ADDRESS_WIDTH,
  parameter int DEPTH = ARENA_DEPTH,
  parameter logic [DATA_WIDTH-1:0] SENTINEL =
    DATA_WIDTH'(ARENA_SENTINEL)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [DATA_WIDTH-1:0]    query,
  output logic                     busy,
  output logic                     done,
  output logic                     hit,
  output logic [ADDRESS_WIDTH-1:0] hitAddr,
  output logic [ADDRESS_WIDTH-1:0] ramAddr,
  output logic                     ramReadEn,
  input  logic [DATA_WIDTH-1:0]    ramData
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST =
    ADDRESS_WIDTH'(DEPTH - 1);

  scan_state_t state, nxt;

  logic [ADDRESS_WIDTH-1:0] cnt;
  logic [ADDRESS_WIDTH-1:0] taddr;
  logic [DATA_WIDTH-1:0]    q;
  logic                     vld;
  logic                     cmp;
  logic                     is_sent;
  logic                     is_eq;
  logic                     found;
  logic                     term;

  // Data only counts while a scan is live; the read issued in the
  // terminating cycle returns in DONE and is ignored there.
  assign cmp     = vld && (state == S_SCAN || state == S_DRAIN);
  assign is_sent = (ramData == SENTINEL);
  assign is_eq   = (ramData == q);
  assign found   = cmp && !is_sent && is_eq;
  assign term    = cmp && (is_sent || is_eq || taddr == LAST);

  // Outputs decode straight from state so reset clears them at once.
  assign busy      = (state == S_SCAN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign ramReadEn = (state == S_SCAN);
  assign ramAddr   = cnt;

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (start) nxt = S_SCAN;
      S_SCAN: begin
        if (term)             nxt = S_DONE;
        else if (cnt == LAST) nxt = S_DRAIN;
      end
      S_DRAIN: if (term) nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      taddr   <= '0;
      q       <= '0;
      vld     <= 1'b0;
      hit     <= 1'b0;
      hitAddr <= '0;
    end else begin
      state <= nxt;
      vld   <= (state == S_SCAN);
      taddr <= cnt;
      if (state == S_IDLE && start) begin
        q       <= query;
        cnt     <= '0;
        hit     <= 1'b0;
        hitAddr <= '0;
      end
      if (state == S_SCAN && cnt != LAST)
        cnt <= cnt + 1'b1;
      if (found) begin
        hit     <= 1'b1;
        hitAddr <= taddr;
      end
    end
  end

endmodule

// File: tb/tb_arena_border_scanner.sv
// Self-checking bench for arena_border_scanner.
// Drives a behavioural RAM and compares against a list-search model.
module tb_arena_border_scanner;
  import arena_pkg::*;

  localparam int DEP = 1024;
  localparam logic [31:0] SENT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] query;
  logic [31:0] ramData;
  logic        busy, done, hit, ramReadEn;
  logic [9:0]  hitAddr, ramAddr;

  logic [31:0] mem [DEP];

  int checks = 0;
  int errors = 0;

  arena_border_scanner dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .query(query),
    .busy(busy),
    .done(done),
    .hit(hit),
    .hitAddr(hitAddr),
    .ramAddr(ramAddr),
    .ramReadEn(ramReadEn),
    .ramData(ramData)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ramReadEn) ramData <= mem[ramAddr];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First entry that is the sentinel or equals the query ends the list.
  function automatic void model(input logic [31:0] qv,
                                output logic h,
                                output int a,
                                output int cyc);
    h = 1'b0;
    a = 0;
    cyc = DEP + 2;
    for (int i = 0; i < DEP; i++) begin
      if (mem[i] === SENT) begin
        cyc = i + 3;
        return;
      end
      if (mem[i] === qv) begin
        h = 1'b1;
        a = i;
        cyc = i + 3;
        return;
      end
    end
  endfunction

  task automatic run(input string tag,
                     input logic [31:0] qv,
                     input int poke);
    logic eh;
    int   ea, ec, n, maxa, gaps, emax;
    bit   got;
    model(qv, eh, ea, ec);
    emax = (ec - 2 > DEP - 1) ? DEP - 1 : ec - 2;
    @(negedge clk);
    start = 1'b1;
    query = qv;
    @(posedge clk);
    #1;
    start = 1'b0;
    query = ~qv;
    n = 0;
    maxa = -1;
    gaps = 0;
    got = 1'b0;
    while (n < DEP + 20) begin
      @(negedge clk);
      n++;
      if (done) begin
        got = 1'b1;
        break;
      end
      if (!busy) gaps++;
      if (ramReadEn && int'(ramAddr) > maxa) maxa = int'(ramAddr);
      if (poke != 0 && n == poke) begin
        start = 1'b1;
        query = qv + 32'd1;
      end
      if (poke != 0 && n == poke + 1) start = 1'b0;
    end
    start = 1'b0;
    chk({tag, " done seen"}, 32'(got), 32'd1);
    chk({tag, " done cycle"}, n, ec);
    chk({tag, " hit"}, 32'(hit), 32'(eh));
    chk({tag, " hitAddr"}, 32'(hitAddr), ea);
    chk({tag, " last read"}, maxa, emax);
    chk({tag, " busy gaps"}, gaps, 0);
    chk({tag, " busy at done"}, 32'(busy), 32'd0);
    chk({tag, " rden at done"}, 32'(ramReadEn), 32'd0);
    @(negedge clk);
    chk({tag, " done pulse"}, 32'(done), 32'd0);
    chk({tag, " hit held"}, 32'(hit), 32'(eh));
  endtask

  task automatic load_small();
    for (int i = 0; i < DEP; i++) mem[i] = 32'(i + 100);
    mem[0] = 32'd10;
    mem[1] = 32'd20;
    mem[2] = 32'd30;
    mem[3] = 32'd40;
    mem[4] = 32'd50;
    mem[5] = SENT;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    query = '0;
    for (int i = 0; i < DEP; i++) mem[i] = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst hit", 32'(hit), 32'd0);
    chk("rst hitAddr", 32'(hitAddr), 32'd0);
    chk("rst ramAddr", 32'(ramAddr), 32'd0);
    chk("rst rden", 32'(ramReadEn), 32'd0);
    reset = 1'b0;

    load_small();
    run("q30", 32'd30, 0);
    run("q99", 32'd99, 0);
    run("q40 poke", 32'd40, 2);

    for (int i = 0; i < DEP; i++) mem[i] = 32'(i + 5000);
    run("full last", mem[DEP-1], 0);
    run("full absent", 32'd1, 0);
    run("full first", mem[0], 0);

    // Reset in the middle of a scan must clear outputs without a clock.
    load_small();
    @(negedge clk);
    start = 1'b1;
    query = 32'd99;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid busy before", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid busy", 32'(busy), 32'd0);
    chk("mid rden", 32'(ramReadEn), 32'd0);
    chk("mid hit", 32'(hit), 32'd0);
    chk("mid ramAddr", 32'(ramAddr), 32'd0);
    chk("mid done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run("after rst", 32'd20, 0);

    mem[0] = SENT;
    run("sent query", SENT, 0);

    for (int it = 0; it < 8; it++) begin
      int sp;
      for (int i = 0; i < DEP; i++)
        mem[i] = $urandom & 32'h0000_03FF;
      sp = $urandom_range(0, 1) != 0 ? int'($urandom_range(0, 60)) : -1;
      if (sp >= 0) mem[sp] = SENT;
      if ($urandom_range(0, 1) != 0)
        query = mem[$urandom_range(0, 70)];
      else
        query = $urandom & 32'h0000_0FFF;
      run($sformatf("rand%0d", it), query, it == 3 ? 4 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
